// File: rtl/ssd_frame_writer_pkg.sv
// ssd_frame_writer_pkg
//   Shared types and constants for the seven-segment frame writer.
//   Segment vectors are ordered {g,f,e,d,c,b,a} and are active low
//   (0 = segment lit).
package ssd_frame_writer_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;  // lowercase b
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;  // lowercase d
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   typedef struct packed {
      logic       blank;
      logic [3:0] hex;
      logic       dp;
      logic       blink;
   } digit_t;

   localparam digit_t DIGIT_BLANK = '{blank: 1'b1, hex: 4'h0, dp: 1'b0, blink: 1'b0};

endpackage

// File: rtl/ssd_hex_encoder.sv
// ssd_hex_encoder
//   Combinational hex/blank to active-low seven-segment glyph.
//   hex_i   : 4-bit value 0..F
//   blank_i : forces all segments off
//   seg_o   : {g,f,e,d,c,b,a}, 0 = lit
module ssd_hex_encoder
   import ssd_frame_writer_pkg::*;
(
   input  logic [3:0] hex_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         unique case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/ssd_frame_writer.sv
// ssd_frame_writer
//   Holds an 8-digit frame written over a valid/ready port, encodes each
//   digit to active-low segments, applies per-digit blinking and presents
//   registered per-segment buses to the scan driver (bit i = digit i).
//   clk_i, rst_ni           : clock, async active-low reset
//   wr_valid_i / wr_ready_o : write handshake
//   wr_addr_i, wr_data_i    : digit index, {blank, hex[3:0]}
//   wr_dp_i, wr_blink_i     : decimal point, blink enable
//   clear_i / busy_o        : blank-whole-frame request / in progress
//   a_o..g_o, p_o           : active-low segment buses
module ssd_frame_writer
   import ssd_frame_writer_pkg::*;
#(
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       wr_valid_i,
   output logic       wr_ready_o,
   input  logic [2:0] wr_addr_i,
   input  logic [4:0] wr_data_i,
   input  logic       wr_dp_i,
   input  logic       wr_blink_i,
   input  logic       clear_i,
   output logic       busy_o,
   output logic [7:0] a_o,
   output logic [7:0] b_o,
   output logic [7:0] c_o,
   output logic [7:0] d_o,
   output logic [7:0] e_o,
   output logic [7:0] f_o,
   output logic [7:0] g_o,
   output logic [7:0] p_o
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

   state_e     state_q, state_d;
   logic [2:0] clr_addr_q, clr_addr_d;
   digit_t     frame_q [NUM_DIGITS];
   logic [CNT_W-1:0] cnt_q;
   logic       blink_phase_q;
   logic [7:0] seg_d [NUM_DIGITS];
   logic [7:0] seg_q [NUM_DIGITS];
   logic       wr_fire;

   // clear takes priority: a write presented alongside clear is refused
   assign wr_ready_o = (state_q == ST_IDLE) && !clear_i;
   assign busy_o     = (state_q == ST_CLEAR);
   assign wr_fire    = wr_valid_i && wr_ready_o;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clear_i) begin
               state_d    = ST_CLEAR;
               clr_addr_d = 3'd0;
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + 3'd1;
            if (clr_addr_q == 3'd7) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         clr_addr_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_DIGITS; i++) frame_q[i] <= DIGIT_BLANK;
      end else if (state_q == ST_CLEAR) begin
         frame_q[clr_addr_q] <= DIGIT_BLANK;
      end else if (wr_fire) begin
         frame_q[wr_addr_i] <= '{blank: wr_data_i[4], hex: wr_data_i[3:0],
                                 dp: wr_dp_i, blink: wr_blink_i};
      end
   end

   // Free-running blink timebase; writes never disturb it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q         <= '0;
         blink_phase_q <= 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q         <= '0;
         blink_phase_q <= !blink_phase_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [6:0] glyph;
      ssd_hex_encoder u_enc (
         .hex_i   (frame_q[i].hex),
         .blank_i (frame_q[i].blank),
         .seg_o   (glyph)
      );
      // blink-off phase darkens the decimal point too
      assign seg_d[i] = (frame_q[i].blink && blink_phase_q) ? 8'hFF
                                                            : {!frame_q[i].dp, glyph};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= 8'hFF;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= seg_d[i];
      end
   end

   // Transpose per-digit bytes into per-segment buses.
   always_comb begin
      a_o = '1; b_o = '1; c_o = '1; d_o = '1;
      e_o = '1; f_o = '1; g_o = '1; p_o = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         a_o[i] = seg_q[i][0];
         b_o[i] = seg_q[i][1];
         c_o[i] = seg_q[i][2];
         d_o[i] = seg_q[i][3];
         e_o[i] = seg_q[i][4];
         f_o[i] = seg_q[i][5];
         g_o[i] = seg_q[i][6];
         p_o[i] = seg_q[i][7];
      end
   end

endmodule
